// File: rtl/sram_arb_pkg.sv
// Shared defaults and node-entry layout for the SRAM port arbiter.
// The optional write-acknowledge feature is selected by SRAM_ARB_WR_ACK_EN (see sram_port_arbiter).
package sram_arb_pkg;

  localparam int N_REQ_DEF      = 2;
  localparam int ADDR_WIDTH_DEF = 4;
  localparam int DATA_WIDTH_DEF = 34;
  localparam int RD_LAT_DEF     = 1;

  localparam int TAG_WIDTH = $clog2(N_REQ_DEF);

  // Node entry {f0, f1, f2, f3} with f0 in the MSBs.
  localparam int F0_W = 8;
  localparam int F1_W = 8;
  localparam int F2_W = 8;
  localparam int F3_W = 10;
  localparam int F3_OFF = 0;
  localparam int F2_OFF = F3_OFF + F3_W;
  localparam int F1_OFF = F2_OFF + F2_W;
  localparam int F0_OFF = F1_OFF + F1_W;

  function automatic logic [DATA_WIDTH_DEF-1:0] pack_node(
    input logic [F0_W-1:0] f0,
    input logic [F1_W-1:0] f1,
    input logic [F2_W-1:0] f2,
    input logic [F3_W-1:0] f3
  );
    logic [DATA_WIDTH_DEF-1:0] w;
    w = '0;
    w[F0_OFF +: F0_W] = f0;
    w[F1_OFF +: F1_W] = f1;
    w[F2_OFF +: F2_W] = f2;
    w[F3_OFF +: F3_W] = f3;
    return w;
  endfunction

endpackage

// File: rtl/sram_port_arbiter_if.sv
// Request/response and SRAM-side bundle of the SRAM port arbiter.
// master = requesters plus SRAM (environment); slave = the arbiter itself.
interface sram_port_arbiter_if #(
  parameter int N_REQ      = sram_arb_pkg::N_REQ_DEF,
  parameter int ADDR_WIDTH = sram_arb_pkg::ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = sram_arb_pkg::DATA_WIDTH_DEF
) ();

  logic [N_REQ-1:0]            i_req_valid;
  logic [N_REQ-1:0]            o_req_ready;
  logic [N_REQ-1:0]            i_req_write;
  logic [N_REQ*ADDR_WIDTH-1:0] i_req_addr;
  logic [N_REQ*DATA_WIDTH-1:0] i_req_data;
  logic [N_REQ-1:0]            o_rsp_valid;
  logic [DATA_WIDTH-1:0]       o_rsp_data;
  logic [ADDR_WIDTH-1:0]       o_sram_addr;
  logic                        o_sram_write;
  logic [DATA_WIDTH-1:0]       o_sram_data;
  logic [DATA_WIDTH-1:0]       i_sram_data;

  modport master (
    output i_req_valid, i_req_write, i_req_addr, i_req_data, i_sram_data,
    input  o_req_ready, o_rsp_valid, o_rsp_data, o_sram_addr, o_sram_write, o_sram_data
  );

  modport slave (
    input  i_req_valid, i_req_write, i_req_addr, i_req_data, i_sram_data,
    output o_req_ready, o_rsp_valid, o_rsp_data, o_sram_addr, o_sram_write, o_sram_data
  );

endinterface

// File: rtl/sram_port_arbiter_rr_arbiter.sv
// N-wide round-robin arbiter: the granted index becomes the lowest priority
// after each accept strobe. Pointer resets to N-1 so index 0 wins first.
module rr_arbiter #(
  parameter int N = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         req,
  input  logic                 accept,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] grant_idx
);

  localparam int IW = $clog2(N);

  logic [IW-1:0] ptr_q;

  // NOTE: every output gets a default before the loop, so no path leaves one unassigned (no latch).
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    // Walk from farthest to nearest so the nearest requester after the pointer wins.
    for (int i = N; i >= 1; i--) begin
      if (req[IW'((int'(ptr_q) + i) % N)]) begin
        grant                                = '0;
        grant[IW'((int'(ptr_q) + i) % N)]    = 1'b1;
        grant_idx                            = IW'((int'(ptr_q) + i) % N);
      end
    end
  end

  // NOTE: state registers use non-blocking assignment so all flops update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= IW'(N - 1);
    end else if (accept) begin
      ptr_q <= grant_idx;
    end
  end

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one single-port SRAM between N_REQ requesters with round-robin grant and tagged
// read-response routing. Define SRAM_ARB_WR_ACK_EN to also acknowledge writes.
module sram_port_arbiter
  import sram_arb_pkg::*;
#(
  parameter int N_REQ      = N_REQ_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int RD_LAT     = RD_LAT_DEF
) (
  input logic               i_clk,
  input logic               i_rst_n,
  sram_port_arbiter_if.slave bus
);

  localparam int IDX_W = $clog2(N_REQ);

`ifdef SRAM_ARB_WR_ACK_EN
  localparam bit WR_ACK = 1'b1;
`else
  localparam bit WR_ACK = 1'b0;
`endif

  typedef struct packed {
    logic             vld;
    logic [IDX_W-1:0] idx;
  } tag_t;

  logic [N_REQ-1:0]      grant;
  logic [IDX_W-1:0]      grant_idx;
  logic                  accept;
  logic                  sram_write_q;
  logic [ADDR_WIDTH-1:0] sram_addr_q;
  logic [DATA_WIDTH-1:0] sram_data_q;
  logic [DATA_WIDTH-1:0] rsp_data_q;
  logic [DATA_WIDTH-1:0] rsp_src;
  logic [N_REQ-1:0]      rsp_valid;
  tag_t                  tag_q [RD_LAT+1];

  rr_arbiter #(.N(N_REQ)) u_rr (
    .clk      (i_clk),
    .rst_n    (i_rst_n),
    .req      (bus.i_req_valid),
    .accept   (accept),
    .grant    (grant),
    .grant_idx(grant_idx)
  );

  // Ready is forced low while reset is held even if requests are pending.
  assign bus.o_req_ready = i_rst_n ? grant : '0;
  assign accept          = |bus.o_req_ready;

  // tag_q[0] travels with the command cycle; tag_q[RD_LAT] lines up with SRAM read data.
  // NOTE: the tag pipeline is reset because a stale valid bit would fire a phantom response.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sram_write_q <= 1'b0;
      sram_addr_q  <= '0;
      sram_data_q  <= '0;
      rsp_data_q   <= '0;
      for (int i = 0; i <= RD_LAT; i++) tag_q[i] <= '0;
    end else begin
      sram_write_q <= accept && bus.i_req_write[grant_idx];
      if (accept) begin
        sram_addr_q <= bus.i_req_addr[grant_idx*ADDR_WIDTH +: ADDR_WIDTH];
        sram_data_q <= bus.i_req_data[grant_idx*DATA_WIDTH +: DATA_WIDTH];
      end
      tag_q[0].vld <= accept && (WR_ACK || !bus.i_req_write[grant_idx]);
      tag_q[0].idx <= grant_idx;
      for (int i = 1; i <= RD_LAT; i++) tag_q[i] <= tag_q[i-1];
      if (tag_q[RD_LAT].vld) rsp_data_q <= rsp_src;
    end
  end

`ifdef SRAM_ARB_WR_ACK_EN
  logic [RD_LAT:0]       ack_wr_q;
  logic [DATA_WIDTH-1:0] ack_data_q [RD_LAT+1];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ack_wr_q <= '0;
    end else begin
      ack_wr_q <= {ack_wr_q[RD_LAT-1:0], accept && bus.i_req_write[grant_idx]};
    end
  end

  // Write data only matters when qualified by ack_wr_q, so it needs no reset.
  always_ff @(posedge i_clk) begin
    ack_data_q[0] <= bus.i_req_data[grant_idx*DATA_WIDTH +: DATA_WIDTH];
    for (int i = 1; i <= RD_LAT; i++) ack_data_q[i] <= ack_data_q[i-1];
  end

  assign rsp_src = ack_wr_q[RD_LAT] ? ack_data_q[RD_LAT] : bus.i_sram_data;
`else
  assign rsp_src = bus.i_sram_data;
`endif

  always_comb begin
    rsp_valid = '0;
    if (tag_q[RD_LAT].vld) rsp_valid[tag_q[RD_LAT].idx] = 1'b1;
  end

  assign bus.o_rsp_valid  = rsp_valid;
  assign bus.o_rsp_data   = tag_q[RD_LAT].vld ? rsp_src : rsp_data_q;
  assign bus.o_sram_write = sram_write_q;
  assign bus.o_sram_addr  = sram_addr_q;
  assign bus.o_sram_data  = sram_data_q;

endmodule
